wsg_pwm_dac: RTL and testbench
==============================

WSG_PWM_DAC -- requirements
Module: wsg_pwm_dac

Interface
REQ-001 Parameter: CNT_BITS, default 8, PWM carrier counter width; period = 2^CNT_BITS clk cycles.
REQ-002 Parameter: RAMP_STEP, default 4, per-period level change while muting or unmuting.
REQ-003 clk  input  1  sole clock, 96 kHz sound clock domain; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 sample_dat  input  8  unsigned mixed WSG sample (0 = silence floor).
REQ-006 sample_valid  input  1  sample_dat valid this cycle.
REQ-007 sample_ready  output  1  block can accept a sample this cycle.
REQ-008 mute  input  1  level request; 1 = ramp output to 0.
REQ-009 pwm_out  output  1  registered PWM bitstream to the external low-pass filter.
REQ-010 frame_start  output  1  one-cycle pulse aligned with the first pwm_out bit of each period.
REQ-011 underrun  output  1  one-cycle pulse when a period boundary finds no pending sample.
REQ-012 underrun_cnt  output  8  saturating underrun count.

Function
REQ-013 Counter cnt SHALL run 0..2^CNT_BITS-1 and wrap to 0; boundary = cycle where cnt is all ones.
REQ-014 One-entry pending buffer: sample_ready = not pend_full; transfer on sample_valid & sample_ready sets pend_full and captures sample_dat.
REQ-015 At a boundary with pend_full=1: duty <= pending value, pend_full <= 0; sample_ready SHALL reassert the following cycle.
REQ-016 At a boundary with pend_full=0: duty held, underrun pulses 1 cycle, underrun_cnt increments, saturating at 255.
REQ-017 A transfer on the boundary cycle itself SHALL be impossible while full; a transfer into an empty buffer on the boundary cycle loads at the next boundary (no bypass) and counts as an underrun for the current boundary.
REQ-018 Level lvl drives the comparator; pwm_out SHALL be high for exactly lvl cycles per period (bits 0..lvl-1 high), so lvl=0 gives constant low.
REQ-019 Latency: a sample accepted in period N SHALL set the pwm_out duty for period N+1 (PLAY state), first bit flagged by frame_start.
REQ-020 Level FSM states PLAY, RAMP_DOWN, MUTED, RAMP_UP; transitions and lvl updates only at boundaries.
REQ-021 PLAY: lvl = new duty; mute=1 -> RAMP_DOWN.
REQ-022 RAMP_DOWN: lvl = max(lvl-RAMP_STEP, 0); reaching 0 -> MUTED; mute=0 -> RAMP_UP from current lvl.
REQ-023 MUTED: lvl = 0; mute=0 -> RAMP_UP.
REQ-024 RAMP_UP: lvl = min(lvl+RAMP_STEP, duty); lvl = duty -> PLAY; mute=1 -> RAMP_DOWN.
REQ-025 Samples SHALL be consumed and underruns counted in every FSM state.
REQ-026 Ramp arithmetic SHALL use one extra bit internally; no wrap-around of lvl.

Reset
REQ-027 While reset=0: cnt=0, pend_full=0, duty=0, lvl=0, FSM=PLAY, pwm_out=0, frame_start=0, underrun=0, underrun_cnt=0, sample_ready=0.
REQ-028 sample_ready SHALL be 1 the first cycle after reset deasserts.
REQ-029 Reset mid-period or mid-ramp SHALL discard the pending sample and restart at cnt=0.

Structure
REQ-030 Shared package wsg_pkg: level FSM state enum, CNT_BITS and RAMP_STEP defaults, sample width 8.
REQ-031 One sub-module wsg_level_ramp (FSM plus lvl register); counter, buffer and comparator stay in the top.

Verification
REQ-032 Reset, then sample 0x40 accepted in period 0 -> period 1 has 64 high pwm_out cycles starting at frame_start; ready 0 until the first boundary.
REQ-033 No samples after reset -> underrun pulses once per period; underrun_cnt saturates at 255 after 300 periods.
REQ-034 Samples 0x00 then 0xFF -> period all low, then 255 high plus 1 low.
REQ-035 Duty 0x10, mute=1 -> lvl 12, 8, 4, 0 over four boundaries, then MUTED; mute=0 -> 4, 8, 12, 16, then PLAY.
REQ-036 Mute dropped after two down-steps (duty 0x20: 28, 24) -> RAMP_UP 28, 32, PLAY; no lvl underflow or overflow.
REQ-037 reset=0 asserted mid-period with pend_full=1 -> next cycle all outputs at reset values; first post-reset boundary flags underrun.

Source files
------------

// File: rtl/wsg_pkg.sv
// Shared definitions for the WSG PWM DAC: sample width, parameter defaults
// and the output-level state machine encoding.
package wsg_pkg;

    localparam int SAMPLE_W      = 8;
    localparam int CNT_BITS_DEF  = 8;
    localparam int RAMP_STEP_DEF = 4;

    typedef enum logic [1:0] {
        LVL_PLAY      = 2'd0,
        LVL_RAMP_DOWN = 2'd1,
        LVL_MUTED     = 2'd2,
        LVL_RAMP_UP   = 2'd3
    } lvl_state_e;

endpackage

// File: rtl/wsg_level_ramp.sv
// Output level tracker: follows the duty while playing and ramps to/from zero
// in RAMP_STEP increments on mute requests, changing only at period boundaries.
module wsg_level_ramp
    import wsg_pkg::*;
#(
    parameter int RAMP_STEP = RAMP_STEP_DEF
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                boundary,
    input  logic                mute,
    input  logic [SAMPLE_W-1:0] duty_new,
    output logic [SAMPLE_W-1:0] lvl
);

    localparam logic [SAMPLE_W:0] STEP_EXT = (SAMPLE_W+1)'(RAMP_STEP);

    lvl_state_e          state;
    logic [SAMPLE_W-1:0] lvl_dn;
    logic [SAMPLE_W-1:0] lvl_up;

    // The extra top bit catches the borrow so the level floors at zero.
    function automatic logic [SAMPLE_W-1:0] sat_down(input logic [SAMPLE_W-1:0] v);
        logic [SAMPLE_W:0] d;
        d = {1'b0, v} - STEP_EXT;
        return d[SAMPLE_W] ? '0 : d[SAMPLE_W-1:0];
    endfunction

    function automatic logic [SAMPLE_W-1:0] sat_up(input logic [SAMPLE_W-1:0] v,
                                                   input logic [SAMPLE_W-1:0] tgt);
        logic [SAMPLE_W:0] s;
        s = {1'b0, v} + STEP_EXT;
        return (s > {1'b0, tgt}) ? tgt : s[SAMPLE_W-1:0];
    endfunction

    assign lvl_dn = sat_down(lvl);
    assign lvl_up = sat_up(lvl, duty_new);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LVL_PLAY;
            lvl   <= '0;
        end else if (boundary) begin
            case (state)
                LVL_PLAY: begin
                    if (mute) begin
                        lvl   <= lvl_dn;
                        state <= (lvl_dn == '0) ? LVL_MUTED : LVL_RAMP_DOWN;
                    end else begin
                        lvl   <= duty_new;
                    end
                end
                LVL_RAMP_DOWN, LVL_RAMP_UP: begin
                    if (mute) begin
                        lvl   <= lvl_dn;
                        state <= (lvl_dn == '0) ? LVL_MUTED : LVL_RAMP_DOWN;
                    end else begin
                        lvl   <= lvl_up;
                        state <= (lvl_up == duty_new) ? LVL_PLAY : LVL_RAMP_UP;
                    end
                end
                LVL_MUTED: begin
                    if (mute) begin
                        lvl   <= '0;
                    end else begin
                        lvl   <= lvl_up;
                        state <= (lvl_up == duty_new) ? LVL_PLAY : LVL_RAMP_UP;
                    end
                end
                default: begin
                    lvl   <= '0;
                    state <= LVL_PLAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/wsg_pwm_dac.sv
// WSG sound PWM DAC: one-entry sample buffer, free-running carrier counter
// and registered comparator driving the external low-pass filter.
module wsg_pwm_dac
    import wsg_pkg::*;
#(
    parameter int CNT_BITS  = CNT_BITS_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_dat,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                mute,
    output logic                pwm_out,
    output logic                frame_start,
    output logic                underrun,
    output logic [7:0]          underrun_cnt
);

    localparam int CMP_W = (CNT_BITS > SAMPLE_W) ? CNT_BITS : SAMPLE_W;

    logic [CNT_BITS-1:0] cnt;
    logic                pend_full;
    logic [SAMPLE_W-1:0] pend_dat;
    logic [SAMPLE_W-1:0] duty;
    logic [SAMPLE_W-1:0] duty_new;
    logic [SAMPLE_W-1:0] lvl;
    logic                rst_done;
    logic                boundary;
    logic                xfer;

    assign boundary     = &cnt;
    assign sample_ready = rst_done & ~pend_full;
    assign xfer         = sample_valid & sample_ready;
    assign duty_new     = pend_full ? pend_dat : duty;

    // Comparator is registered, so pwm_out lags cnt by one cycle; frame_start
    // is delayed identically so it marks bit 0 of each period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt          <= '0;
            pend_full    <= 1'b0;
            duty         <= '0;
            rst_done     <= 1'b0;
            pwm_out      <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            cnt         <= cnt + 1'b1;
            rst_done    <= 1'b1;
            pwm_out     <= (CMP_W'(cnt) < CMP_W'(lvl));
            frame_start <= (cnt == '0);
            underrun    <= 1'b0;
            if (boundary) begin
                if (pend_full) begin
                    duty      <= pend_dat;
                    pend_full <= 1'b0;
                end else begin
                    underrun <= 1'b1;
                    if (underrun_cnt != 8'hFF)
                        underrun_cnt <= underrun_cnt + 8'd1;
                end
            end
            // Only reachable with an empty buffer, so it never races the drain.
            if (xfer)
                pend_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer)
            pend_dat <= sample_dat;
    end

    wsg_level_ramp #(
        .RAMP_STEP (RAMP_STEP)
    ) u_level (
        .clk      (clk),
        .reset    (reset),
        .boundary (boundary),
        .mute     (mute),
        .duty_new (duty_new),
        .lvl      (lvl)
    );

endmodule

// File: tb/tb_wsg_pwm_dac.sv
// Bench for wsg_pwm_dac: hand-derived vector table, corner sequences and a
// period-level reference model for randomized traffic.
module tb_wsg_pwm_dac;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sample_dat;
    logic       sample_valid;
    logic       sample_ready;
    logic       mute;
    logic       pwm_out;
    logic       frame_start;
    logic       underrun;
    logic [7:0] underrun_cnt;

    logic       reset_s;
    logic [7:0] sample_dat_s = 8'h00;
    logic       sample_valid_s = 1'b0;
    logic       mute_s = 1'b0;
    logic       sample_ready_s;
    logic       pwm_out_s;
    logic       frame_start_s;
    logic       underrun_s;
    logic [7:0] underrun_cnt_s;

    always #5 clk = ~clk;

    wsg_pwm_dac #(.CNT_BITS(8), .RAMP_STEP(4)) dut (
        .clk(clk), .reset(reset), .sample_dat(sample_dat), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .mute(mute), .pwm_out(pwm_out),
        .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    // Short-period copy used only for the long underrun saturation run.
    wsg_pwm_dac #(.CNT_BITS(4), .RAMP_STEP(4)) dut_s (
        .clk(clk), .reset(reset_s), .sample_dat(sample_dat_s), .sample_valid(sample_valid_s),
        .sample_ready(sample_ready_s), .mute(mute_s), .pwm_out(pwm_out_s),
        .frame_start(frame_start_s), .underrun(underrun_s), .underrun_cnt(underrun_cnt_s)
    );

    int total = 0;
    int bad   = 0;
    bit sat_done = 1'b0;

    typedef struct {
        bit         sv;
        logic [7:0] sd;
        bit         m;
        int         exp_hi;
        bit         exp_urn;
    } vec_t;

    vec_t tbl[20];

    // period-level reference state
    int m_lvl, m_duty, m_pv, m_ucnt;
    bit m_pend, m_play;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl = 0; m_duty = 0; m_pv = 0; m_ucnt = 0; m_pend = 1'b0; m_play = 1'b1;
    endtask

    task automatic apply_reset(input int n, input string tag);
        reset = 1'b0; sample_valid = 1'b0; sample_dat = 8'h00; mute = 1'b0;
        repeat (n) @(negedge clk);
        check({tag, "_rst_pwm"},   pwm_out, 0);
        check({tag, "_rst_fs"},    frame_start, 0);
        check({tag, "_rst_urn"},   underrun, 0);
        check({tag, "_rst_ucnt"},  underrun_cnt, 0);
        check({tag, "_rst_ready"}, sample_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_post_ready"}, sample_ready, 1);
        check({tag, "_post_fs"},    frame_start, 1);
    endtask

    // Runs one PWM period starting at the negedge showing frame_start; offers a
    // sample at bit index at_i when sv is set and holds mute for the period.
    task automatic run_period(input bit sv, input logic [7:0] sd, input int at_i, input bit m,
                              output int hi, output bit shape_ok, output int urn,
                              output bit rdy100, output int fs_extra, output int ucnt);
        int  guard;
        bit  seen_low;
        guard = 0;
        while (frame_start !== 1'b1 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 600) check("frame_sync_timeout", 0, 1);
        mute = m;
        hi = 0; shape_ok = 1'b1; urn = 0; rdy100 = 1'b0; fs_extra = 0; seen_low = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            if (i > 0 && frame_start) fs_extra++;
            if (pwm_out) begin
                hi++;
                if (seen_low) shape_ok = 1'b0;
            end else begin
                seen_low = 1'b1;
            end
            if (underrun) urn++;
            if (i == 100) rdy100 = sample_ready;
            if (sv && i == at_i) begin
                sample_valid = 1'b1;
                sample_dat   = sd;
            end else begin
                sample_valid = 1'b0;
            end
        end
        ucnt = underrun_cnt;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // One period of random traffic compared with the reference model.
    task automatic model_period(input bit sv, input logic [7:0] sd, input int at_i,
                                input bit m, input int k);
        int  hi, urn, fsx, ucnt, exp_hi;
        bit  shp, rdy, exp_rdy, exp_urn, late;
        exp_hi  = m_lvl;
        exp_rdy = !(m_pend || (sv && at_i < 100));
        run_period(sv, sd, at_i, m, hi, shp, urn, rdy, fsx, ucnt);
        if (sv && at_i <= 253 && !m_pend) begin
            m_pend = 1'b1; m_pv = sd;
        end
        late = sv && ((at_i == 254 && !m_pend) || at_i == 255);
        if (m_pend) begin
            m_duty = m_pv; m_pend = 1'b0; exp_urn = 1'b0;
        end else begin
            exp_urn = 1'b1;
            if (m_ucnt < 255) m_ucnt++;
        end
        if (late) begin
            m_pend = 1'b1; m_pv = sd;
        end
        if (m) begin
            m_lvl  = (m_lvl < 4) ? 0 : m_lvl - 4;
            m_play = 1'b0;
        end else if (m_play) begin
            m_lvl = m_duty;
        end else begin
            m_lvl  = (m_lvl + 4 > m_duty) ? m_duty : m_lvl + 4;
            m_play = (m_lvl == m_duty);
        end
        check($sformatf("rnd%0d_hi", k), hi, exp_hi);
        check($sformatf("rnd%0d_shape", k), shp, 1);
        check($sformatf("rnd%0d_urn", k), urn, exp_urn);
        check($sformatf("rnd%0d_ready", k), rdy, exp_rdy);
        check($sformatf("rnd%0d_fs", k), fsx, 0);
        check($sformatf("rnd%0d_ucnt", k), ucnt, m_ucnt);
    endtask

    initial begin
        int  hi, urn, fsx, ucnt, at_i, r;
        bit  shp, rdy, mr;

        tbl[0]  = '{1'b1, 8'h40, 1'b0,   0, 1'b0};
        tbl[1]  = '{1'b1, 8'h00, 1'b0,  64, 1'b0};
        tbl[2]  = '{1'b1, 8'hFF, 1'b0,   0, 1'b0};
        tbl[3]  = '{1'b1, 8'h10, 1'b0, 255, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1,  16, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1,  12, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1,   8, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b1,   4, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1,   0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0,   0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0,   4, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0,   8, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b0,  12, 1'b1};
        tbl[13] = '{1'b1, 8'h20, 1'b0,  16, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b1,  32, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b1,  28, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b0,  24, 1'b1};
        tbl[17] = '{1'b0, 8'h00, 1'b0,  28, 1'b1};
        tbl[18] = '{1'b1, 8'h40, 1'b0,  32, 1'b0};
        tbl[19] = '{1'b0, 8'h00, 1'b0,  64, 1'b1};

        apply_reset(3, "init");

        for (int k = 0; k < 20; k++) begin
            run_period(tbl[k].sv, tbl[k].sd, 0, tbl[k].m, hi, shp, urn, rdy, fsx, ucnt);
            check($sformatf("tbl%0d_hi", k), hi, tbl[k].exp_hi);
            check($sformatf("tbl%0d_shape", k), shp, 1);
            check($sformatf("tbl%0d_urn", k), urn, tbl[k].exp_urn);
            check($sformatf("tbl%0d_ready", k), rdy, !tbl[k].sv);
            check($sformatf("tbl%0d_fs", k), fsx, 0);
        end

        // Transfer on the boundary cycle: no bypass, underrun for that boundary.
        apply_reset(2, "bnd");
        run_period(1'b1, 8'h30, 254, 1'b0, hi, shp, urn, rdy, fsx, ucnt);
        check("bnd0_hi", hi, 0);
        check("bnd0_urn", urn, 1);
        check("bnd0_ready", rdy, 1);
        run_period(1'b0, 8'h00, 0, 1'b0, hi, shp, urn, rdy, fsx, ucnt);
        check("bnd1_hi", hi, 0);
        check("bnd1_urn", urn, 0);
        check("bnd1_ready", rdy, 0);
        run_period(1'b0, 8'h00, 0, 1'b0, hi, shp, urn, rdy, fsx, ucnt);
        check("bnd2_hi", hi, 48);
        check("bnd2_urn", urn, 1);
        check("bnd2_ucnt", ucnt, 2);

        // Reset mid-period with a sample pending.
        r = 0;
        while (frame_start !== 1'b1 && r < 600) begin
            @(negedge clk);
            r++;
        end
        sample_valid = 1'b1; sample_dat = 8'h99;
        @(negedge clk);
        sample_valid = 1'b0;
        check("mid_pend_ready", sample_ready, 0);
        repeat (40) @(negedge clk);
        check("mid_pwm_high", pwm_out, 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_pwm", pwm_out, 0);
        check("mid_rst_fs", frame_start, 0);
        check("mid_rst_urn", underrun, 0);
        check("mid_rst_ucnt", underrun_cnt, 0);
        check("mid_rst_ready", sample_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_post_ready", sample_ready, 1);
        run_period(1'b0, 8'h00, 0, 1'b0, hi, shp, urn, rdy, fsx, ucnt);
        check("mid_after_hi", hi, 0);
        check("mid_after_urn", urn, 1);
        check("mid_after_ucnt", ucnt, 1);

        // Randomized traffic against the period-level model.
        apply_reset(2, "rnd");
        model_reset();
        mr = 1'b0;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            at_i = (r == 0) ? 254 : (r == 1) ? 255 : (r == 2) ? 253 : $urandom_range(0, 200);
            if ($urandom_range(0, 4) == 0) mr = !mr;
            model_period($urandom_range(0, 3) != 0, 8'($urandom), at_i, mr, k);
        end

        r = 0;
        while (!sat_done && r < 20000) begin
            @(negedge clk);
            r++;
        end
        check("sat_thread_done", sat_done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Underrun saturation on the short-period instance, no samples at all.
    initial begin
        int pulses, last, gap_bad, cyc, fs, pwm_hi;
        pulses = 0; last = -1; gap_bad = 0; cyc = 0; fs = 0; pwm_hi = 0;
        reset_s = 1'b0;
        repeat (3) @(negedge clk);
        reset_s = 1'b1;
        while (pulses < 300 && cyc < 300 * 16 + 200) begin
            @(negedge clk);
            cyc++;
            if (underrun_s) begin
                pulses++;
                if (last >= 0 && cyc - last != 16) gap_bad++;
                last = cyc;
                if (pulses == 100) check("sat_ucnt_100", underrun_cnt_s, 100);
                if (pulses == 255) check("sat_ucnt_255", underrun_cnt_s, 255);
            end
            if (frame_start_s) fs++;
            if (pwm_out_s) pwm_hi++;
        end
        check("sat_pulses", pulses, 300);
        check("sat_gap", gap_bad, 0);
        check("sat_ucnt_final", underrun_cnt_s, 255);
        check("sat_pwm_low", pwm_hi, 0);
        check("sat_ready", sample_ready_s, 1);
        check("sat_frames", fs >= 299, 1);
        sat_done = 1'b1;
    end

endmodule
